// File: rtl/nios2_oci_dct_pack_ctrl.sv
// Packs 2-bit trace atoms into 15-atom words with flush and output backpressure.
// Build option: NIOS2_OCI_DCT_DROP_CNT_EN enables the saturating dropped-atom counter.
module nios2_oci_dct_pack_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    input  logic        flush,
    input  logic        test_ending,
    output logic        atom_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] out_data,
    output logic [3:0]  out_count,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic [7:0]  drop_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        flush_pend;
    logic        flush_pend_nxt;
    logic        slot_free;
    logic        flush_now;
    logic        emit;
    logic        accept;
    logic [29:0] buf_nxt;
    logic [3:0]  cnt_nxt;

    assign slot_free  = !out_valid || out_ready;
    assign flush_now  = flush || test_ending;
    // HOLD covers both a full buffer and a deferred flush.
    assign emit       = slot_free &&
                        ((state == HOLD) || (flush_now && state == FILL));
    assign atom_ready = (dct_count != 4'd15) || emit;
    assign accept     = atom_valid && atom_ready;

    // Next buffer contents, pending-flush flag and packer state.
    always_comb begin
        buf_nxt        = dct_buffer;
        cnt_nxt        = dct_count;
        flush_pend_nxt = flush_pend;
        state_nxt      = state;
        if (emit) begin
            buf_nxt        = '0;
            cnt_nxt        = '0;
            flush_pend_nxt = 1'b0;
        end else if (flush_now && dct_count != 4'd0 && !slot_free) begin
            flush_pend_nxt = 1'b1;
        end
        if (accept) begin
            buf_nxt = buf_nxt | (30'(atom_data) << {cnt_nxt, 1'b0});
            cnt_nxt = cnt_nxt + 4'd1;
        end
        unique case (1'b1)
            (cnt_nxt == 4'd0):                      state_nxt = IDLE;
            (cnt_nxt == 4'd15) || flush_pend_nxt:   state_nxt = HOLD;
            default:                                state_nxt = FILL;
        endcase
    end

    // Packing buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            flush_pend <= 1'b0;
            state      <= IDLE;
        end else begin
            dct_buffer <= buf_nxt;
            dct_count  <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
            state      <= state_nxt;
        end
    end

    // Output word slot; held stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (emit) begin
            out_data  <= dct_buffer;
            out_count <= dct_count;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
    // Count atoms refused while the buffer is full, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (atom_valid && !atom_ready && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_pack_ctrl.sv
// Self-checking bench for nios2_oci_dct_pack_ctrl.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_nios2_oci_dct_pack_ctrl;

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'd0;
    logic        flush = 1'b0;
    logic        test_ending = 1'b0;
    logic        atom_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    nios2_oci_dct_pack_ctrl dut (
        .clk        (clk),
        .reset      (rst),
        .atom_valid (atom_valid),
        .atom_data  (atom_data),
        .flush      (flush),
        .test_ending(test_ending),
        .atom_ready (atom_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of buffered atoms and one output slot.
    logic [1:0]  m_q[$];
    bit          m_pend;
    bit          m_ov;
    logic [29:0] m_od;
    int          m_oc;
    int          m_drop;
    bit          m_e;
    bit          m_r;
    bit          m_sf;

    function automatic bit exp_emit();
        bit sf;
        bit fr;
        sf = !m_ov || out_ready;
        fr = flush || test_ending || m_pend;
        return sf && (m_q.size() == 15 || (fr && m_q.size() != 0));
    endfunction

    function automatic bit exp_ready();
        return (m_q.size() < 15) || exp_emit();
    endfunction

    function automatic logic [29:0] pack_q();
        logic [29:0] w;
        w = '0;
        for (int k = 0; k < m_q.size(); k++)
            w = w | (30'(m_q[k]) << (2 * k));
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_pend = 0;
            m_ov   = 0;
            m_od   = '0;
            m_oc   = 0;
            m_drop = 0;
        end else begin
            m_e  = exp_emit();
            m_r  = exp_ready();
            m_sf = !m_ov || out_ready;
            if (atom_valid && !m_r && DROP_EN != 0 && m_drop < 255)
                m_drop++;
            if (m_e) begin
                m_od   = pack_q();
                m_oc   = m_q.size();
                m_ov   = 1;
                m_pend = 0;
                m_q.delete();
            end else begin
                if (m_ov && out_ready)
                    m_ov = 0;
                if ((flush || test_ending) && m_q.size() != 0 && !m_sf)
                    m_pend = 1;
            end
            if (atom_valid && m_r)
                m_q.push_back(atom_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        atom_valid  = 1'b0;
        atom_data   = 2'd0;
        flush       = 1'b0;
        test_ending = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_atoms(input int n, input logic [1:0] d);
        for (int i = 0; i < n; i++) begin
            atom_valid = 1'b1;
            atom_data  = d;
            tick();
        end
        atom_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        n_checks += 7;
        if (dct_buffer !== 30'd0) begin
            n_fail++; $display("FAIL rst_dct_buffer got %h want 0", dct_buffer);
        end
        if (dct_count !== 4'd0) begin
            n_fail++; $display("FAIL rst_dct_count got %0d want 0", dct_count);
        end
        if (out_data !== 30'd0) begin
            n_fail++; $display("FAIL rst_out_data got %h want 0", out_data);
        end
        if (out_count !== 4'd0) begin
            n_fail++; $display("FAIL rst_out_count got %0d want 0", out_count);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        if (drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt);
        end
        if (atom_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_atom_ready got %b want 1", atom_ready);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_word();
        apply_reset();
        out_ready = 1'b1;
        push_atoms(15, 2'b01);
        n_checks++;
        if (dct_count !== 4'd15) begin
            n_fail++; $display("FAIL full_fill_count got %0d want 15", dct_count);
        end
        tick();
        n_checks += 4;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_out_valid got %b want 1", out_valid);
        end
        if (out_data !== 30'h15555555) begin
            n_fail++; $display("FAIL full_out_data got %h want 15555555", out_data);
        end
        if (out_count !== 4'd15) begin
            n_fail++; $display("FAIL full_out_count got %0d want 15", out_count);
        end
        if (dct_count !== 4'd0) begin
            n_fail++; $display("FAIL full_dct_count got %0d want 0", dct_count);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_out_clear got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush_partial();
        apply_reset();
        out_ready = 1'b1;
        push_atoms(1, 2'd3);
        push_atoms(1, 2'd2);
        push_atoms(1, 2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks += 4;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush3_out_valid got %b want 1", out_valid);
        end
        if (out_data !== 30'h0000001B) begin
            n_fail++; $display("FAIL flush3_out_data got %h want 0000001b", out_data);
        end
        if (out_count !== 4'd3) begin
            n_fail++; $display("FAIL flush3_out_count got %0d want 3", out_count);
        end
        if (dct_count !== 4'd0) begin
            n_fail++; $display("FAIL flush3_dct_count got %0d want 0", dct_count);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty_out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        push_atoms(15, 2'b01);
        tick();
        push_atoms(15, 2'b01);
        n_checks++;
        if (dct_count !== 4'd15) begin
            n_fail++; $display("FAIL ovf_fill_count got %0d want 15", dct_count);
        end
        atom_valid = 1'b1;
        atom_data  = 2'd3;
        #1;
        n_checks++;
        if (atom_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_atom_ready got %b want 0", atom_ready);
        end
        tick();
        atom_valid = 1'b0;
        n_checks += 3;
        if (dct_count !== 4'd15) begin
            n_fail++; $display("FAIL ovf_dct_count got %0d want 15", dct_count);
        end
        if (drop_cnt !== 8'(DROP_EN)) begin
            n_fail++; $display("FAIL ovf_drop_cnt got %0d want %0d", drop_cnt, DROP_EN);
        end
        if (out_count !== 4'd15 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_out_stable got v=%b c=%0d want v=1 c=15", out_valid, out_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] slot0;
        out_ready  = 1'b1;
        atom_valid = 1'b1;
        atom_data  = 2'd2;
        #1;
        n_checks++;
        if (atom_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_atom_ready got %b want 1", atom_ready);
        end
        tick();
        atom_valid = 1'b0;
        out_ready  = 1'b0;
        slot0 = dct_buffer[1:0];
        n_checks += 4;
        if (dct_count !== 4'd1) begin
            n_fail++; $display("FAIL b2b_dct_count got %0d want 1", dct_count);
        end
        if (slot0 !== 2'd2) begin
            n_fail++; $display("FAIL b2b_slot0 got %0d want 2", slot0);
        end
        if (out_valid !== 1'b1 || out_count !== 4'd15) begin
            n_fail++; $display("FAIL b2b_out got v=%b c=%0d want v=1 c=15", out_valid, out_count);
        end
        if (out_data !== 30'h15555555) begin
            n_fail++; $display("FAIL b2b_out_data got %h want 15555555", out_data);
        end
    endtask

    task automatic test_flush_pending();
        logic [1:0]  a[4];
        logic [29:0] w;
        apply_reset();
        out_ready = 1'b0;
        push_atoms(15, 2'b10);
        tick();
        w = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 2'($urandom_range(0, 3));
            w = w | (30'(a[i]) << (2 * i));
            push_atoms(1, a[i]);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks += 2;
        if (out_valid !== 1'b1 || out_count !== 4'd15) begin
            n_fail++; $display("FAIL pend_stall got v=%b c=%0d want v=1 c=15", out_valid, out_count);
        end
        if (dct_count !== 4'd4) begin
            n_fail++; $display("FAIL pend_hold_count got %0d want 4", dct_count);
        end
        out_ready = 1'b1;
        tick();
        n_checks += 3;
        if (out_valid !== 1'b1 || out_count !== 4'd4) begin
            n_fail++; $display("FAIL pend_emit got v=%b c=%0d want v=1 c=4", out_valid, out_count);
        end
        if (out_data !== w) begin
            n_fail++; $display("FAIL pend_out_data got %h want %h", out_data, w);
        end
        if (dct_count !== 4'd0) begin
            n_fail++; $display("FAIL pend_dct_count got %0d want 0", dct_count);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL pend_cleared got %b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        push_atoms(7, 2'd3);
        n_checks++;
        if (dct_count !== 4'd7) begin
            n_fail++; $display("FAIL midrst_fill got %0d want 7", dct_count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (dct_count !== 4'd0 || dct_buffer !== 30'd0) begin
            n_fail++; $display("FAIL midrst_buffer got c=%0d b=%h want 0", dct_count, dct_buffer);
        end
        if (out_valid !== 1'b0 || out_count !== 4'd0) begin
            n_fail++; $display("FAIL midrst_out got v=%b c=%0d want 0", out_valid, out_count);
        end
        if (out_data !== 30'd0) begin
            n_fail++; $display("FAIL midrst_out_data got %h want 0", out_data);
        end
        tick();
        rst = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_word got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        int stall_bias;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) stall_bias = $urandom_range(0, 3);
            atom_valid  = ($urandom_range(0, 3) != 0);
            atom_data   = 2'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 15) == 0);
            test_ending = ($urandom_range(0, 127) == 0);
            out_ready   = ($urandom_range(0, 3) >= stall_bias);
            #1;
            n_checks++;
            if (atom_ready !== exp_ready()) begin
                n_fail++; $display("FAIL rnd_atom_ready cyc %0d got %b want %b", c, atom_ready, exp_ready());
            end
            tick();
            n_checks += 4;
            if (dct_count !== 4'(m_q.size()) || dct_buffer !== pack_q()) begin
                n_fail++; $display("FAIL rnd_buffer cyc %0d got c=%0d b=%h want c=%0d b=%h", c, dct_count, dct_buffer, m_q.size(), pack_q());
            end
            if (out_valid !== m_ov) begin
                n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, m_ov);
            end
            if (out_data !== m_od || out_count !== 4'(m_oc)) begin
                n_fail++; $display("FAIL rnd_out_word cyc %0d got %h/%0d want %h/%0d", c, out_data, out_count, m_od, m_oc);
            end
            if (drop_cnt !== 8'(m_drop)) begin
                n_fail++; $display("FAIL rnd_drop_cnt cyc %0d got %0d want %0d", c, drop_cnt, m_drop);
            end
        end
        idle_inputs();
        out_ready = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_full_word();
        test_flush_partial();
        test_overflow();
        test_back_to_back();
        test_flush_pending();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
